// File: rtl/gf2m_pkg.sv
// Shared constants for the GF(2^m) digit-serial multiplier: default field
// size, digit width, the cycles-per-product helper, FSM encoding and the
// NIST B-163 style reduction polynomial.
package gf2m_pkg;

    localparam int M_DEFAULT = 163;
    localparam int D_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // x^163 + x^7 + x^6 + x^3 + 1, low coefficients only (x^163 is implicit)
    localparam logic [162:0] POLY163_G = 163'h0C9;

    // Number of RUN cycles needed to consume all M multiplier bits D at a time
    function automatic int calc_k(input int m, input int d);
        return (m + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_digit_mul_if.sv
// Handshake and operand bus of the digit-serial multiplier. The master
// requests a product, the slave (the multiplier) reports busy/done/result.
interface gf2m_digit_mul_if
    import gf2m_pkg::*;
#(
    parameter int M = M_DEFAULT
);

    logic         start;
    logic [M-1:0] a_in;
    logic [M-1:0] b_in;
    logic [M-1:0] g_in;
    logic         busy;
    logic         done;
    logic [M-1:0] c_out;

    modport master (
        output start, a_in, b_in, g_in,
        input  busy, done, c_out
    );

    modport slave (
        input  start, a_in, b_in, g_in,
        output busy, done, c_out
    );

endinterface

// File: rtl/gf2m_bit_row.sv
// One step of MSB-first shift-and-add multiplication in GF(2^m): multiply the
// accumulator by x, fold the overflowing x^M term back through g, and add a
// if the current multiplier bit is set.
module gf2m_bit_row #(
    parameter int M = 163
) (
    input  logic [M-1:0] t_in,
    input  logic [M-1:0] a,
    input  logic [M-1:0] g,
    input  logic         bb,
    output logic [M-1:0] t_out
);

    logic         s;
    logic [M-1:0] t_shift;

    assign s = t_in[M-1];

    // A one-bit field has nothing to shift in from below
    if (M == 1) begin : g_single
        assign t_shift = '0;
    end else begin : g_multi
        assign t_shift = {t_in[M-2:0], 1'b0};
    end

    assign t_out = t_shift ^ (a & {M{bb}}) ^ (g & {M{s}});

endmodule

// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^m) multiplier: c = a*b mod (x^M + g). Consumes D bits of
// b per cycle, most significant digit first, through a chain of D bit rows,
// so a product takes K = ceil(M/D) RUN cycles plus one DONE cycle.
module gf2m_digit_mul
    import gf2m_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int D = D_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    gf2m_digit_mul_if.slave   bus
);

    localparam int K  = calc_k(M, D);
    localparam int KD = K * D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    logic [1:0]    state;
    logic [M-1:0]  a_reg;
    logic [M-1:0]  g_reg;
    logic [M-1:0]  t_reg;
    logic [M-1:0]  c_reg;
    logic [M-1:0]  t_next;
    logic [KD-1:0] b_sh;
    logic [CW-1:0] cnt;
    logic [D-1:0]  digit;

    // b is zero-padded on the MSB side, so the leading digit may only shift
    // a zero accumulator; the top D bits of the shifter are the live digit.
    assign digit = b_sh[KD-1 -: D];

    // Row r handles digit bit D-1-r, so the highest bit goes in first
    for (genvar r = 0; r < D; r++) begin : g_row
        logic [M-1:0] t_i;
        logic [M-1:0] t_o;

        if (r == 0) begin : g_first
            assign t_i = t_reg;
        end else begin : g_next
            assign t_i = g_row[r-1].t_o;
        end

        gf2m_bit_row #(
            .M (M)
        ) u_row (
            .t_in  (t_i),
            .a     (a_reg),
            .g     (g_reg),
            .bb    (digit[D-1-r]),
            .t_out (t_o)
        );
    end

    assign t_next = g_row[D-1].t_o;

    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign bus.c_out = c_reg;

    // Control FSM and datapath registers: accept in IDLE, iterate in RUN, pulse in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_reg <= '0;
            g_reg <= '0;
            b_sh  <= '0;
            t_reg <= '0;
            c_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.a_in;
                        g_reg <= bus.g_in;
                        b_sh  <= KD'(bus.b_in);
                        t_reg <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    t_reg <= t_next;
                    b_sh  <= b_sh << D;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        c_reg <= t_next;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gf2m_digit_mul.md
GF2M_DIGIT_MUL -- requirements
Module: gf2m_digit_mul

Interface
REQ-001 Parameter M, default 163: field degree.
REQ-002 Parameter D, default 32: digits (b bits) consumed per cycle, legal range 1..M.
REQ-003 Derived constant K = ceil(M/D): compute cycles per product, 6 at defaults.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port start, input, 1: request a product, honoured only when busy=0.
REQ-007 Port a_in, input, M: multiplicand, polynomial basis, bit i = coefficient of x^i.
REQ-008 Port b_in, input, M: multiplier, same encoding.
REQ-009 Port g_in, input, M: reduction polynomial low coefficients; the x^M term is implicit.
REQ-010 Port busy, output, 1: product in progress.
REQ-011 Port done, output, 1: single-cycle pulse, c_out valid.
REQ-012 Port c_out, output, M: a*b mod (x^M + g).

Function
REQ-013 The FSM SHALL have exactly 3 states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, the block SHALL register a_in, b_in and g_in, clear accumulator T to 0, clear digit counter cnt to 0, and enter RUN.
REQ-015 b SHALL be zero-extended on the MSB side to K*D bits; digit j = bits [(K-j)*D-1 : (K-j-1)*D], consumed MSB-first.
REQ-016 Each RUN cycle SHALL apply D chained rows, highest b bit first; per row, with s = T[M-1] and bit bb: T'[0] = (a[0]&bb) ^ (g[0]&s); T'[i] = T[i-1] ^ (a[i]&bb) ^ (g[i]&s) for i = 1..M-1.
REQ-017 In RUN, cnt SHALL increment each cycle; on the cycle where cnt = K-1, the FSM SHALL load c_out with the final T and enter DONE.
REQ-018 done SHALL be 1 only in DONE, lasting exactly 1 cycle; DONE SHALL return to IDLE unconditionally.
REQ-019 busy SHALL be 1 in RUN only; start sampled on edge E0 yields done high in the cycle after edge E(K), a latency of K+1 edges.
REQ-020 start while busy=1 or in DONE SHALL be ignored, with no effect on operands, T or cnt.
REQ-021 c_out SHALL hold its last result until the next DONE entry and SHALL NOT change during RUN.
REQ-022 a_in, b_in and g_in SHALL be don't-care outside the start-acceptance cycle.
REQ-023 D = M SHALL give K = 1, a single RUN cycle.
REQ-024 When M is not a multiple of D, the leading padding zeros SHALL only shift a zero T, so the result equals the unpadded product.

Reset
REQ-025 rst=1 SHALL force IDLE, busy=0, done=0, c_out=0, T=0, cnt=0 at the next edge, with priority over start and any RUN progress.
REQ-026 rst asserted mid-RUN SHALL abort the product with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Structure
REQ-027 Shared package gf2m_pkg SHALL hold the M and D defaults, a function for K, the state encoding, and the constant POLY163_G: bits 7, 6, 3 and 0 set (x^163+x^7+x^6+x^3+1).
REQ-028 One combinational sub-module, gf2m_bit_row, parameter M, SHALL implement one REQ-016 row: inputs T, a, g, bb; output T'.
REQ-029 D instances of gf2m_bit_row SHALL be chained by generate, between the T register and its next-state input.
REQ-030 The design SHALL NOT use multipliers or memories; it is XOR/AND logic plus registers only.

Verification
REQ-031 M=163, D=32, g=POLY163_G: a=1, b=1, start 1 cycle -> busy for 6 cycles, then done for 1 cycle, c_out=1.
REQ-032 a=x^162, b=x -> c_out = x^7+x^6+x^3+1 (hex 0C9).
REQ-033 1000 random a and b with g=POLY163_G -> c_out matches a bit-serial reference model; repeat with D=1 (latency 164 edges), D=7 and D=163 (latency 2 edges).
REQ-034 Hold start=1 continuously -> products complete back-to-back every K+2 cycles; start pulses during RUN and DONE are ignored, and changing a_in mid-RUN leaves the result unchanged.
REQ-035 Assert rst at RUN cycle 3 -> no done pulse, busy=0 and c_out=0 the next cycle; a following a=1, b=1 product returns c_out=1.
